mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single cache_controller request port between the CPU data port and the graphite VRAM port, running in the clk_cpu domain. It replaces the stall-the-CPU-while-graphite-is-busy scheme with registered grants, round-robin fairness and bounded bursts. It also maps graphite's 16-bit halfword accesses onto 32-bit cache words at GFX_BASE.

## Interface
Parameters:
- GFX_BASE, 32'h0100_0000, byte base address of the graphite VRAM window in cache address space.
- MAX_BURST, 4, maximum consecutive completions per owner while the other requester waits (≥1).

Ports:
- clk_cpu  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cpu_sel_i  in  1  CPU memory request; held until cpu_ack_o
- cpu_we_i  in  1  CPU write
- cpu_wmask_i  in  4  CPU byte enables
- cpu_addr_i  in  32  CPU byte address
- cpu_wdata_i  in  32  CPU write data
- cpu_rdata_o  out  32  read data, valid with cpu_ack_o
- cpu_ack_o  out  1  CPU transaction complete
- gfx_sel_i  in  1  graphite request; held until gfx_ack_o
- gfx_we_i  in  1  graphite write
- gfx_addr_i  in  32  graphite halfword address
- gfx_wdata_i  in  16  graphite write data
- gfx_rdata_o  out  16  read halfword, valid with gfx_ack_o
- gfx_ack_o  out  1  graphite transaction complete
- mem_addr_o  out  26  cache_controller address
- mem_din_o  out  32  cache_controller write data
- mem_mreq_o  out  1  cache_controller request
- mem_wmask_o  out  4  cache_controller byte write enables (0 = read)
- mem_dout_i  in  32  cache_controller read data
- mem_rdy_i  in  1  cache_controller ready (CE); completion when mem_mreq_o & mem_rdy_i
- grant_o  out  2  current grant (NONE=0, CPU=1, GFX=2)

## Operation
- State grant ∈ {NONE, CPU, GFX}, registered; last_owner bit, burst counter cnt (clog2(MAX_BURST+1) bits).
- NONE: mem_mreq_o=0. If exactly one sel is high, grant it next cycle. If both are high, grant the requester that is not last_owner. If none is high, stay in NONE.
- CPU/GFX: mux the owner's signals to the mem port; mem_mreq_o = owner sel.
- Completion (mreq & mem_rdy_i): owner ack=1 the same cycle; cnt+1; last_owner←owner.
  - On completion, if the other sel is high and cnt+1 ≥ MAX_BURST: grant←other, cnt←0.
  - Otherwise keep the grant; the owner may present its next request in the following cycle.
- Owner sel low while granted (no completion): grant←NONE, cnt←0.
- CPU mapping: mem_addr=cpu_addr[25:0]; mem_din=cpu_wdata; mem_wmask=cpu_wmask & {4{cpu_we}}.
- GFX mapping:
  - mem_addr = (GFX_BASE + {gfx_addr[30:1],2'b0})[25:0].
  - mem_din = {gfx_wdata, gfx_wdata}.
  - mem_wmask = gfx_addr[0] ? {gfx_we,gfx_we,2'b0} : {2'b0,gfx_we,gfx_we}.
  - gfx_rdata = gfx_addr[0] ? mem_dout[31:16] : mem_dout[15:0].
- cpu_rdata_o = mem_dout_i unconditionally. Acks are never asserted for a non-owner.

## Timing
- Reset values: grant=NONE, last_owner=GFX (CPU wins the first tie), cnt=0; all acks 0, mem_mreq_o=0, grant_o=0.
- Arbitration latency from NONE: 1 cycle (sel seen in cycle n, mreq in cycle n+1). Back-to-back requests within a grant: 0 bubbles.
- Acks are combinational from mem_rdy_i and last exactly one cycle per transaction. mem_rdy_i low stalls indefinitely; the owner holds its request.
- Address and data outputs are combinational muxes selected by the registered grant. No path from sel_i to mem_*_o is combinational through the grant decision.
- Reset mid-transaction: the next cycle forces NONE and deasserts mem_mreq_o. An in-flight request is dropped and never acked.
- Simultaneous completion and switch: the ack goes to the old owner, and the new owner drives the port the next cycle with no NONE bubble.

## Structure
- Package soc_arb_pkg: typedef enum logic [1:0] grant_t {GNT_NONE, GNT_CPU, GNT_GFX}; holds the GFX_BASE default constant.
- One sub-module, rr_pick2: a combinational two-way round-robin pick from {req[1:0], last_owner}.
- The lane and address mapping stays inline in the top module.

## Test plan
- CPU read only, addr 0x0000_0100, mem_rdy_i=1 → mreq in cycle 1, mem_addr=0x100, wmask=0, cpu_ack in cycle 1, rdata=mem_dout.
- GFX write to addr 5, data 0xABCD → mem_addr=0x0100_0008, din=0xABCD_ABCD, wmask=4'b1100, gfx_ack one cycle.
- Both requesting continuously, MAX_BURST=4, rdy=1 → ack pattern CPU×4, GFX×4, CPU×4…, with no idle cycles after the first grant.
- mem_rdy_i low for 10 cycles during a GFX grant → mreq held, no ack, addr/data stable, single ack when rdy rises.
- rst_n low for 1 cycle mid-grant → grant_o=0, mreq=0 next cycle, no ack; tie afterwards goes to CPU.
- Owner drops sel after 2 completions with the other idle → grant_o returns to 0 one cycle later, cnt reset; a later request on either port is re-granted after 1 cycle.

Source files
------------

// File: rtl/soc_arb_pkg.sv
// Shared types for the CPU/graphite memory arbiter.
// Grant encoding and VRAM window default.
package soc_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_GFX  = 2'd2
  } grant_t;

  localparam logic [31:0] GFX_BASE_DEF = 32'h0100_0000;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick.
// On a tie the requester that did not own last wins.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  // i_last=1 means index 1 owned most recently
  always_comb begin
    o_gnt = 2'b00;
    unique case (1'b1)
      (i_req == 2'b11): o_gnt = i_last ? 2'b01 : 2'b10;
      (i_req == 2'b01): o_gnt = 2'b01;
      (i_req == 2'b10): o_gnt = 2'b10;
      default:          o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// CPU / graphite arbiter in front of the cache port.
// Registered grant, round-robin ties, bounded bursts.
module mem_arbiter
  import soc_arb_pkg::*;
#(
  parameter logic [31:0] GFX_BASE  = GFX_BASE_DEF,
  parameter int          MAX_BURST = 4
) (
  input  logic        clk_cpu,
  input  logic        rst_n,
  input  logic        cpu_sel_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_wmask_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ack_o,
  input  logic        gfx_sel_i,
  input  logic        gfx_we_i,
  input  logic [31:0] gfx_addr_i,
  input  logic [15:0] gfx_wdata_i,
  output logic [15:0] gfx_rdata_o,
  output logic        gfx_ack_o,
  output logic [25:0] mem_addr_o,
  output logic [31:0] mem_din_o,
  output logic        mem_mreq_o,
  output logic [3:0]  mem_wmask_o,
  input  logic [31:0] mem_dout_i,
  input  logic        mem_rdy_i,
  output logic [1:0]  grant_o
);

  localparam int CW = $clog2(MAX_BURST + 1);

  grant_t        r_gnt;
  logic          r_last;
  logic [CW-1:0] r_cnt;

  logic       w_own_sel;
  logic       w_oth_sel;
  logic       w_done;
  logic       w_burst_end;
  logic [1:0] w_pick;
  logic       w_unused;

  rr_pick2 u_pick (
    .i_req  ({gfx_sel_i, cpu_sel_i}),
    .i_last (r_last),
    .o_gnt  (w_pick)
  );

  // owner / contender request lines for the current grant
  always_comb begin
    w_own_sel = 1'b0;
    w_oth_sel = 1'b0;
    case (r_gnt)
      GNT_CPU: begin
        w_own_sel = cpu_sel_i;
        w_oth_sel = gfx_sel_i;
      end
      GNT_GFX: begin
        w_own_sel = gfx_sel_i;
        w_oth_sel = cpu_sel_i;
      end
      default: ;
    endcase
  end

  assign w_done      = w_own_sel & mem_rdy_i;
  assign w_burst_end = (32'(r_cnt) + 32'd1) >= 32'(MAX_BURST);

  // grant FSM with burst counter and tie-break history
  always_ff @(posedge clk_cpu) begin
    if (!rst_n) begin
      r_gnt  <= GNT_NONE;
      r_last <= 1'b1;
      r_cnt  <= '0;
    end else begin
      case (r_gnt)
        GNT_NONE: begin
          if (w_pick[0])      r_gnt <= GNT_CPU;
          else if (w_pick[1]) r_gnt <= GNT_GFX;
        end
        GNT_CPU, GNT_GFX: begin
          if (w_done) begin
            r_last <= (r_gnt == GNT_GFX);
            if (w_oth_sel && w_burst_end) begin
              r_gnt <= (r_gnt == GNT_CPU) ? GNT_GFX : GNT_CPU;
              r_cnt <= '0;
            end else if (r_cnt != CW'(MAX_BURST)) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (!w_own_sel) begin
            r_gnt <= GNT_NONE;
            r_cnt <= '0;
          end
        end
        default: begin
          r_gnt <= GNT_NONE;
          r_cnt <= '0;
        end
      endcase
    end
  end

  // port mux and halfword lane mapping
  always_comb begin
    mem_addr_o  = cpu_addr_i[25:0];
    mem_din_o   = cpu_wdata_i;
    mem_wmask_o = cpu_wmask_i & {4{cpu_we_i}};
    if (r_gnt == GNT_GFX) begin
      mem_addr_o  = GFX_BASE[25:0] + {gfx_addr_i[24:1], 2'b00};
      mem_din_o   = {gfx_wdata_i, gfx_wdata_i};
      mem_wmask_o = gfx_addr_i[0] ? {gfx_we_i, gfx_we_i, 2'b00}
                                  : {2'b00, gfx_we_i, gfx_we_i};
    end
  end

  assign mem_mreq_o  = w_own_sel;
  assign cpu_ack_o   = w_done & (r_gnt == GNT_CPU);
  assign gfx_ack_o   = w_done & (r_gnt == GNT_GFX);
  assign cpu_rdata_o = mem_dout_i;
  assign gfx_rdata_o = gfx_addr_i[0] ? mem_dout_i[31:16] : mem_dout_i[15:0];
  assign grant_o     = r_gnt;

  assign w_unused = ^{cpu_addr_i[31:26], gfx_addr_i[31:25]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed steps then random traffic.
// Expectations come from a per-cycle service model.
module tb_mem_arbiter;

  localparam logic [31:0] GBASE = 32'h0100_0000;
  localparam int          MAXB  = 4;

  logic        clk_cpu = 1'b0;
  logic        rst_n;
  logic        cpu_sel_i, cpu_we_i;
  logic [3:0]  cpu_wmask_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic        cpu_ack_o;
  logic        gfx_sel_i, gfx_we_i;
  logic [31:0] gfx_addr_i;
  logic [15:0] gfx_wdata_i, gfx_rdata_o;
  logic        gfx_ack_o;
  logic [25:0] mem_addr_o;
  logic [31:0] mem_din_o;
  logic        mem_mreq_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_dout_i;
  logic        mem_rdy_i;
  logic [1:0]  grant_o;

  int total = 0;
  int bad   = 0;

  int m_gnt;
  int m_last;
  int m_cnt;
  bit last_cack, last_gack;
  bit c_busy, g_busy;

  always #5 clk_cpu = ~clk_cpu;

  mem_arbiter #(.GFX_BASE(GBASE), .MAX_BURST(MAXB)) dut (
    .clk_cpu(clk_cpu), .rst_n(rst_n),
    .cpu_sel_i(cpu_sel_i), .cpu_we_i(cpu_we_i),
    .cpu_wmask_i(cpu_wmask_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o),
    .cpu_ack_o(cpu_ack_o),
    .gfx_sel_i(gfx_sel_i), .gfx_we_i(gfx_we_i),
    .gfx_addr_i(gfx_addr_i), .gfx_wdata_i(gfx_wdata_i),
    .gfx_rdata_o(gfx_rdata_o), .gfx_ack_o(gfx_ack_o),
    .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o),
    .mem_mreq_o(mem_mreq_o), .mem_wmask_o(mem_wmask_o),
    .mem_dout_i(mem_dout_i), .mem_rdy_i(mem_rdy_i),
    .grant_o(grant_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: check outputs against the model, advance the model
  task automatic cyc();
    bit os, xs, done;
    logic [31:0] a, hw;
    #1;
    os = (m_gnt == 1) ? cpu_sel_i : (m_gnt == 2) ? gfx_sel_i : 1'b0;
    xs = (m_gnt == 1) ? gfx_sel_i : (m_gnt == 2) ? cpu_sel_i : 1'b0;
    done = os && mem_rdy_i;
    chk("grant", 32'(grant_o), 32'(m_gnt));
    chk("mreq", 32'(mem_mreq_o), 32'(os));
    chk("cpu_ack", 32'(cpu_ack_o), 32'(done && m_gnt == 1));
    chk("gfx_ack", 32'(gfx_ack_o), 32'(done && m_gnt == 2));
    chk("cpu_rdata", cpu_rdata_o, mem_dout_i);
    if (m_gnt == 1 && os) begin
      chk("cpu_addr", 32'(mem_addr_o), cpu_addr_i % 32'h0400_0000);
      chk("cpu_din", mem_din_o, cpu_wdata_i);
      chk("cpu_wmask", 32'(mem_wmask_o),
          cpu_we_i ? 32'(cpu_wmask_i) : 32'd0);
    end
    if (m_gnt == 2 && os) begin
      a = GBASE + (gfx_addr_i / 2) * 4;
      chk("gfx_addr", 32'(mem_addr_o), a % 32'h0400_0000);
      chk("gfx_din", mem_din_o, 32'(gfx_wdata_i) * 32'h0001_0001);
      chk("gfx_wmask", 32'(mem_wmask_o),
          gfx_we_i ? (32'd3 << (2 * (gfx_addr_i % 2))) : 32'd0);
      hw = (gfx_addr_i % 2 == 1) ? (mem_dout_i >> 16)
                                 : (mem_dout_i % 32'h1_0000);
      if (done) chk("gfx_rdata", 32'(gfx_rdata_o), hw);
    end
    last_cack = done && m_gnt == 1;
    last_gack = done && m_gnt == 2;
    if (!rst_n) begin
      m_gnt = 0; m_last = 2; m_cnt = 0;
    end else if (m_gnt == 0) begin
      if (cpu_sel_i && gfx_sel_i) m_gnt = (m_last == 1) ? 2 : 1;
      else if (cpu_sel_i) m_gnt = 1;
      else if (gfx_sel_i) m_gnt = 2;
    end else if (done) begin
      m_last = m_gnt;
      m_cnt++;
      if (xs && m_cnt >= MAXB) begin
        m_gnt = 3 - m_gnt;
        m_cnt = 0;
      end
    end else if (!os) begin
      m_gnt = 0;
      m_cnt = 0;
    end
    @(negedge clk_cpu);
  endtask

  initial begin
    m_gnt = 0; m_last = 2; m_cnt = 0;
    c_busy = 0; g_busy = 0;
    rst_n = 0;
    cpu_sel_i = 0; cpu_we_i = 0; cpu_wmask_i = 0;
    cpu_addr_i = 0; cpu_wdata_i = 0;
    gfx_sel_i = 0; gfx_we_i = 0; gfx_addr_i = 0; gfx_wdata_i = 0;
    mem_dout_i = 0; mem_rdy_i = 0;
    @(negedge clk_cpu);
    cyc();
    cyc();
    rst_n = 1;

    // reset state
    #1;
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_mreq", 32'(mem_mreq_o), 32'd0);
    cyc();

    // CPU read at 0x100
    cpu_sel_i = 1; cpu_addr_i = 32'h0000_0100; cpu_wmask_i = 4'hF;
    mem_rdy_i = 1; mem_dout_i = 32'h1234_5678;
    #1;
    chk("cpu_rd_lat0", 32'(mem_mreq_o), 32'd0);
    cyc();
    #1;
    chk("cpu_rd_mreq", 32'(mem_mreq_o), 32'd1);
    chk("cpu_rd_addr", 32'(mem_addr_o), 32'h100);
    chk("cpu_rd_wmask", 32'(mem_wmask_o), 32'd0);
    chk("cpu_rd_ack", 32'(cpu_ack_o), 32'd1);
    chk("cpu_rd_data", cpu_rdata_o, 32'h1234_5678);
    cyc();
    cpu_sel_i = 0;
    cyc();

    // GFX write halfword 5
    gfx_sel_i = 1; gfx_we_i = 1; gfx_addr_i = 5; gfx_wdata_i = 16'hABCD;
    cyc();
    #1;
    chk("gfx_wr_addr", 32'(mem_addr_o), 32'h0100_0008);
    chk("gfx_wr_din", mem_din_o, 32'hABCD_ABCD);
    chk("gfx_wr_wmask", 32'(mem_wmask_o), 32'hC);
    chk("gfx_wr_ack", 32'(gfx_ack_o), 32'd1);
    cyc();
    gfx_sel_i = 0;
    cyc();

    // both requesting: bursts of MAXB alternate
    cpu_sel_i = 1; gfx_sel_i = 1; gfx_we_i = 0; gfx_addr_i = 2;
    cyc();
    for (int k = 0; k < 6 * MAXB; k++) begin
      #1;
      chk("burst_cpu", 32'(cpu_ack_o), 32'(((k / MAXB) % 2) == 0));
      chk("burst_gfx", 32'(gfx_ack_o), 32'(((k / MAXB) % 2) == 1));
      cyc();
    end
    cpu_sel_i = 0; gfx_sel_i = 0;
    cyc();
    cyc();

    // stall during a GFX read
    gfx_sel_i = 1; gfx_addr_i = 7; mem_rdy_i = 0;
    cyc();
    for (int k = 0; k < 10; k++) begin
      mem_dout_i = $urandom;
      #1;
      chk("stall_mreq", 32'(mem_mreq_o), 32'd1);
      chk("stall_ack", 32'(gfx_ack_o), 32'd0);
      chk("stall_addr", 32'(mem_addr_o), 32'h0100_000C);
      cyc();
    end
    mem_rdy_i = 1; mem_dout_i = 32'hBEEF_1234;
    #1;
    chk("stall_done_ack", 32'(gfx_ack_o), 32'd1);
    chk("stall_done_data", 32'(gfx_rdata_o), 32'hBEEF);
    cyc();
    gfx_sel_i = 0;
    cyc();

    // reset in the middle of a CPU grant
    cpu_sel_i = 1; mem_rdy_i = 0;
    cyc();
    cyc();
    rst_n = 0;
    cyc();
    rst_n = 1; gfx_sel_i = 1;
    #1;
    chk("mrst_grant", 32'(grant_o), 32'd0);
    chk("mrst_mreq", 32'(mem_mreq_o), 32'd0);
    chk("mrst_ack", 32'({cpu_ack_o, gfx_ack_o}), 32'd0);
    cyc();
    mem_rdy_i = 1;
    #1;
    chk("mrst_tie", 32'(grant_o), 32'd1);
    cyc();
    cpu_sel_i = 0;
    cyc();
    cyc();
    cyc();
    gfx_sel_i = 0;
    cyc();

    // owner drops after two completions
    cpu_sel_i = 1;
    cyc();
    cyc();
    cyc();
    cpu_sel_i = 0;
    cyc();
    #1;
    chk("drop_grant", 32'(grant_o), 32'd0);
    gfx_sel_i = 1;
    cyc();
    #1;
    chk("regrant", 32'(grant_o), 32'd2);
    chk("regrant_mreq", 32'(mem_mreq_o), 32'd1);
    cyc();
    gfx_sel_i = 0;
    cyc();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      if (!c_busy && $urandom_range(2) == 0) begin
        c_busy = 1;
        cpu_we_i = 1'($urandom_range(1));
        cpu_wmask_i = 4'($urandom);
        cpu_addr_i = $urandom;
        cpu_wdata_i = $urandom;
      end
      if (!g_busy && $urandom_range(2) == 0) begin
        g_busy = 1;
        gfx_we_i = 1'($urandom_range(1));
        gfx_addr_i = $urandom;
        gfx_wdata_i = 16'($urandom);
      end
      cpu_sel_i = c_busy;
      gfx_sel_i = g_busy;
      rst_n = ($urandom_range(90) != 0);
      mem_rdy_i = rst_n && ($urandom_range(3) != 0);
      mem_dout_i = $urandom;
      cyc();
      if (last_cack) c_busy = 0;
      if (last_gack) g_busy = 0;
    end
    rst_n = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
